// File: rtl/bin2bcd_seq.sv
// ---------------------------------------------------------------------------
// bin2bcd_seq
//   Sequential binary-to-BCD converter (shift-and-add-3 / double-dabble).
//   Converts one operand bit per clock and presents ones/tens/hunds as
//   registered BCD nibbles that feed one operand of the downstream BCD adder.
//   Handshake: start is sampled only while idle; busy is high during the
//   conversion; done pulses for one cycle on the completing edge.
//
// Parameters
//   WIDTH  binary operand width, legal range 4..10 (default 8)
//
// Ports
//   clk    in   1      system clock, rising edge
//   rst    in   1      synchronous active-high reset
//   start  in   1      conversion request, sampled only when idle
//   bin    in   WIDTH  unsigned operand, captured with an accepted start
//   busy   out  1      conversion in progress
//   done   out  1      one-cycle pulse, digits valid and updated this cycle
//   ones   out  4      BCD ones digit
//   tens   out  4      BCD tens digit
//   hunds  out  4      BCD hundreds digit
//   ovf    out  1      only when BIN2BCD_SAT_EN is defined: operand > 999,
//                      digits saturated to 999
//
// Configuration macro
//   BIN2BCD_SAT_EN  defined   -> saturate operands > 999 and drive ovf
//                   undefined -> no ovf port, result is value mod 1000
// ---------------------------------------------------------------------------
module bin2bcd_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] bin,
    output logic             busy,
    output logic             done,
    output logic [3:0]       ones,
    output logic [3:0]       tens,
    output logic [3:0]       hunds
`ifdef BIN2BCD_SAT_EN
    ,
    output logic             ovf
`endif
);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_SHIFT = 1'b1;

    // Counter value of the final shift cycle.
    localparam logic [3:0] CNT_LAST = 4'(WIDTH - 1);

    // Width of the full shift chain {W1000,W100,W10,W1,shreg}.
    localparam int CHAIN_W = 16 + WIDTH;

    // Double-dabble correction: digits 5..9 get +3 so the following shift
    // carries correctly into the next decade.
    function automatic logic [3:0] add3(input logic [3:0] d);
        if (d >= 4'd5) begin
            return d + 4'd3;
        end else begin
            return d;
        end
    endfunction

    logic [0:0]       state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [3:0]       w1_q, w1_d;
    logic [3:0]       w10_q, w10_d;
    logic [3:0]       w100_q, w100_d;
    logic [3:0]       w1000_q, w1000_d;
    logic [3:0]       ones_q, ones_d;
    logic [3:0]       tens_q, tens_d;
    logic [3:0]       hunds_q, hunds_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
`ifdef BIN2BCD_SAT_EN
    logic             ovf_q, ovf_d;
`endif

    logic [CHAIN_W-1:0] chain_s;
    logic [CHAIN_W-1:0] chain_sh_s;
    logic [3:0]         sh1_s, sh10_s, sh100_s, sh1000_s;
    logic [WIDTH-1:0]   shreg_sh_s;

    // One double-dabble step: correct every working digit, then shift the
    // whole chain left by one so the operand MSB enters W1 bit 0.
    always_comb begin
        chain_s    = {add3(w1000_q), add3(w100_q), add3(w10_q), add3(w1_q), shreg_q};
        chain_sh_s = chain_s << 1;
        sh1000_s   = chain_sh_s[WIDTH+15:WIDTH+12];
        sh100_s    = chain_sh_s[WIDTH+11:WIDTH+8];
        sh10_s     = chain_sh_s[WIDTH+7:WIDTH+4];
        sh1_s      = chain_sh_s[WIDTH+3:WIDTH];
        shreg_sh_s = chain_sh_s[WIDTH-1:0];
    end

    // Next-state logic: IDLE accepts start, SHIFT steps once per clock and
    // loads the result registers on the final step.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        w1_d    = w1_q;
        w10_d   = w10_q;
        w100_d  = w100_q;
        w1000_d = w1000_q;
        ones_d  = ones_q;
        tens_d  = tens_q;
        hunds_d = hunds_q;
        done_d  = 1'b0;
`ifdef BIN2BCD_SAT_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    shreg_d = bin;
                    w1_d    = 4'd0;
                    w10_d   = 4'd0;
                    w100_d  = 4'd0;
                    w1000_d = 4'd0;
                    cnt_d   = 4'd0;
                    state_d = S_SHIFT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SHIFT: begin
                shreg_d = shreg_sh_s;
                w1_d    = sh1_s;
                w10_d   = sh10_s;
                w100_d  = sh100_s;
                w1000_d = sh1000_s;
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = 4'd0;
                    state_d = S_IDLE;
                    done_d  = 1'b1;
`ifdef BIN2BCD_SAT_EN
                    // A nonzero thousands digit means the operand exceeded 999.
                    if (sh1000_s != 4'd0) begin
                        ones_d  = 4'd9;
                        tens_d  = 4'd9;
                        hunds_d = 4'd9;
                        ovf_d   = 1'b1;
                    end else begin
                        ones_d  = sh1_s;
                        tens_d  = sh10_s;
                        hunds_d = sh100_s;
                        ovf_d   = 1'b0;
                    end
`else
                    // Thousands digit is dropped: result is value mod 1000.
                    ones_d  = sh1_s;
                    tens_d  = sh10_s;
                    hunds_d = sh100_s;
`endif
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
        busy_d = (state_d == S_SHIFT);
    end

    // State and output registers with synchronous reset (reset beats start).
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            shreg_q <= '0;
            w1_q    <= 4'd0;
            w10_q   <= 4'd0;
            w100_q  <= 4'd0;
            w1000_q <= 4'd0;
            ones_q  <= 4'd0;
            tens_q  <= 4'd0;
            hunds_q <= 4'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef BIN2BCD_SAT_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            w1_q    <= w1_d;
            w10_q   <= w10_d;
            w100_q  <= w100_d;
            w1000_q <= w1000_d;
            ones_q  <= ones_d;
            tens_q  <= tens_d;
            hunds_q <= hunds_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef BIN2BCD_SAT_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign ones  = ones_q;
    assign tens  = tens_q;
    assign hunds = hunds_q;
`ifdef BIN2BCD_SAT_EN
    assign ovf   = ovf_q;
`endif

endmodule
